// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency single-port memory between fetch (I) and load/store (D) requesters
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_LATENCY = 1,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic                i_flush,
  output logic                i_ack,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [CNT_W-1:0]    conflict_cnt
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t           state_q, state_d;
  logic             own_d_q, own_d_d;
  logic             flush_q, flush_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] conflict_q, conflict_d;
  logic             idle, resp, issue_d, issue_i;
  always_comb begin
    idle = state_q == IDLE && !rst;
    resp = state_q == RESP && !rst;
    issue_d = idle && d_req;
    issue_i = idle && !d_req && i_req && !i_flush;
    mem_en = issue_d || issue_i;
    mem_we = issue_d && d_we;
    mem_addr = issue_d ? d_addr : i_addr;
    mem_wdata = d_wdata;
    mem_wstrb = mem_we ? d_wstrb : '0;
    d_ack = resp && own_d_q;
    i_ack = resp && !own_d_q && !flush_q && !i_flush;
    d_rdata = d_ack ? mem_rdata : '0;
    i_rdata = i_ack ? mem_rdata : '0;
    conflict_cnt = conflict_q;
    state_d = state_q;
    cnt_d = cnt_q;
    own_d_d = own_d_q;
    flush_d = 1'b0;
    conflict_d = (idle && d_req && i_req && !(&conflict_q)) ? conflict_q + 1'b1 : conflict_q;
    if (mem_en) begin
      state_d = MEM_LATENCY == 1 ? RESP : WAIT;
      cnt_d = 4'(MEM_LATENCY - 1);
      own_d_d = issue_d;
    end
    // a fetch can never issue with i_flush high, so the flag only arms while waiting
    if (state_q == WAIT) begin
      cnt_d = cnt_q - 1'b1;
      state_d = cnt_q == 4'd1 ? RESP : WAIT;
      flush_d = flush_q || (!own_d_q && i_flush);
    end
    if (state_q == RESP) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      own_d_q <= 1'b0;
      flush_q <= 1'b0;
      conflict_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      own_d_q <= own_d_d;
      flush_q <= flush_d;
      conflict_q <= conflict_d;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: per-cycle vector table plus directed fetch sequences, MEM_LATENCY=2, CNT_W=2
module tb_mem_port_arbiter;
  localparam logic [31:0] K = 32'h5A5A_0000;
  logic clk = 0, rst;
  logic i_req, i_flush, i_ack, d_req, d_we, d_ack, mem_en, mem_we;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0] d_wstrb, mem_wstrb;
  logic [1:0] conflict_cnt;
  logic [31:0] p0, p1;
  int total = 0, bad = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(2), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_ack(i_ack),
    .i_rdata(i_rdata), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_ack(d_ack), .d_rdata(d_rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .conflict_cnt(conflict_cnt));

  always #5 clk = ~clk;

  // memory model: data = issued address ^ K, valid two cycles after issue
  always @(posedge clk) begin
    p0 <= mem_en ? (mem_addr ^ K) : 32'h0;
    p1 <= p0;
  end
  assign mem_rdata = p1;

  typedef struct {
    logic rst, ir; logic [31:0] ia; logic fl, dr, dw; logic [31:0] da, dwd; logic [3:0] ds;
    logic en, we; logic [31:0] ma; logic [3:0] ws; logic iack, dack; logic [31:0] rd; logic [1:0] cnt;
  } vec_t;
  vec_t vq[$];

  function automatic vec_t v(input logic r, ir, input logic [31:0] ia, input logic fl, dr, dw,
                             input logic [31:0] da, dwd, input logic [3:0] ds, input logic en, we,
                             input logic [31:0] ma, input logic [3:0] ws, input logic iack, dack,
                             input logic [31:0] rd, input logic [1:0] cnt);
    vec_t x;
    x.rst = r; x.ir = ir; x.ia = ia; x.fl = fl; x.dr = dr; x.dw = dw; x.da = da; x.dwd = dwd;
    x.ds = ds; x.en = en; x.we = we; x.ma = ma; x.ws = ws; x.iack = iack; x.dack = dack;
    x.rd = rd; x.cnt = cnt;
    return x;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  task automatic drive(input logic r, ir, input logic [31:0] ia, input logic fl, dr, dw,
                       input logic [31:0] da, dwd, input logic [3:0] ds);
    rst = r; i_req = ir; i_addr = ia; i_flush = fl; d_req = dr; d_we = dw;
    d_addr = da; d_wdata = dwd; d_wstrb = ds;
  endtask

  initial begin
    vec_t r;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // reset with a pending data request, then data priority over a simultaneous fetch
    vq.push_back(v(1,0,0,0,1,0,'h100,0,0, 0,0,0,0,0,0,0,0));
    vq.push_back(v(0,1,'h200,0,1,0,'h100,0,0, 1,0,'h100,0,0,0,0,0));
    vq.push_back(v(0,1,'h200,0,1,0,'h100,0,0, 0,0,0,0,0,0,0,1));
    vq.push_back(v(0,1,'h200,0,1,0,'h100,0,0, 0,0,0,0,0,1,'h5A5A0100,1));
    vq.push_back(v(0,1,'h200,0,0,0,0,0,0, 1,0,'h200,0,0,0,0,1));
    vq.push_back(v(0,1,'h200,0,0,0,0,0,0, 0,0,0,0,0,0,0,1));
    vq.push_back(v(0,1,'h200,0,0,0,0,0,0, 0,0,0,0,1,0,'h5A5A0200,1));
    vq.push_back(v(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,1));
    // store
    vq.push_back(v(0,0,0,0,1,1,'h300,'hDEADBEEF,4'b0011, 1,1,'h300,4'b0011,0,0,0,1));
    vq.push_back(v(0,0,0,0,1,1,'h300,'hDEADBEEF,4'b0011, 0,0,0,0,0,0,0,1));
    vq.push_back(v(0,0,0,0,1,1,'h300,'hDEADBEEF,4'b0011, 0,0,0,0,0,1,0,1));
    vq.push_back(v(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,1));
    // flush while a fetch is in flight, then a fresh fetch
    vq.push_back(v(0,1,'h400,0,0,0,0,0,0, 1,0,'h400,0,0,0,0,1));
    vq.push_back(v(0,1,'h400,1,0,0,0,0,0, 0,0,0,0,0,0,0,1));
    vq.push_back(v(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,1));
    vq.push_back(v(0,1,'h404,0,0,0,0,0,0, 1,0,'h404,0,0,0,0,1));
    vq.push_back(v(0,1,'h404,0,0,0,0,0,0, 0,0,0,0,0,0,0,1));
    vq.push_back(v(0,1,'h404,0,0,0,0,0,0, 0,0,0,0,1,0,'h5A5A0404,1));
    // flush in IDLE blocks the issue for that cycle only
    vq.push_back(v(0,1,'h500,1,0,0,0,0,0, 0,0,0,0,0,0,0,1));
    vq.push_back(v(0,1,'h500,0,0,0,0,0,0, 1,0,'h500,0,0,0,0,1));
    vq.push_back(v(0,1,'h500,0,0,0,0,0,0, 0,0,0,0,0,0,0,1));
    vq.push_back(v(0,1,'h500,0,0,0,0,0,0, 0,0,0,0,1,0,'h5A5A0500,1));
    vq.push_back(v(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,1));
    // flush has no effect on a data access
    vq.push_back(v(0,0,0,1,1,0,'h600,0,0, 1,0,'h600,0,0,0,0,1));
    vq.push_back(v(0,0,0,1,1,0,'h600,0,0, 0,0,0,0,0,0,0,1));
    vq.push_back(v(0,0,0,1,1,0,'h600,0,0, 0,0,0,0,0,1,'h5A5A0600,1));
    vq.push_back(v(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,1));
    // repeated conflicts: counter 1 -> 2 -> 3 -> saturates at 3
    vq.push_back(v(0,1,'h700,0,1,0,'h800,0,0, 1,0,'h800,0,0,0,0,1));
    vq.push_back(v(0,1,'h700,0,1,0,'h800,0,0, 0,0,0,0,0,0,0,2));
    vq.push_back(v(0,1,'h700,0,1,0,'h800,0,0, 0,0,0,0,0,1,'h5A5A0800,2));
    vq.push_back(v(0,1,'h700,0,1,0,'h804,0,0, 1,0,'h804,0,0,0,0,2));
    vq.push_back(v(0,1,'h700,0,1,0,'h804,0,0, 0,0,0,0,0,0,0,3));
    vq.push_back(v(0,1,'h700,0,1,0,'h804,0,0, 0,0,0,0,0,1,'h5A5A0804,3));
    vq.push_back(v(0,1,'h700,0,1,0,'h808,0,0, 1,0,'h808,0,0,0,0,3));
    vq.push_back(v(0,1,'h700,0,1,0,'h808,0,0, 0,0,0,0,0,0,0,3));
    vq.push_back(v(0,1,'h700,0,1,0,'h808,0,0, 0,0,0,0,0,1,'h5A5A0808,3));
    vq.push_back(v(0,1,'h700,0,0,0,0,0,0, 1,0,'h700,0,0,0,0,3));
    vq.push_back(v(0,1,'h700,0,0,0,0,0,0, 0,0,0,0,0,0,0,3));
    vq.push_back(v(0,1,'h700,0,0,0,0,0,0, 0,0,0,0,1,0,'h5A5A0700,3));
    vq.push_back(v(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,3));
    // reset one cycle into a data read: that read is never acked
    vq.push_back(v(0,0,0,0,1,0,'h900,0,0, 1,0,'h900,0,0,0,0,3));
    vq.push_back(v(1,0,0,0,1,0,'h900,0,0, 0,0,0,0,0,0,0,3));
    vq.push_back(v(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));
    vq.push_back(v(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < vq.size(); i++) begin
      r = vq[i];
      drive(r.rst, r.ir, r.ia, r.fl, r.dr, r.dw, r.da, r.dwd, r.ds);
      @(negedge clk);
      chk($sformatf("r%0d mem_en", i), 32'(mem_en), 32'(r.en));
      if (r.en || r.rst) begin
        chk($sformatf("r%0d mem_we", i), 32'(mem_we), 32'(r.we));
        chk($sformatf("r%0d mem_wstrb", i), 32'(mem_wstrb), 32'(r.ws));
      end
      if (r.en) chk($sformatf("r%0d mem_addr", i), mem_addr, r.ma);
      if (r.en && r.we) chk($sformatf("r%0d mem_wdata", i), mem_wdata, r.dwd);
      chk($sformatf("r%0d i_ack", i), 32'(i_ack), 32'(r.iack));
      chk($sformatf("r%0d d_ack", i), 32'(d_ack), 32'(r.dack));
      chk($sformatf("r%0d i_rdata", i), i_rdata, r.iack ? r.rd : 32'h0);
      if (!r.dw) chk($sformatf("r%0d d_rdata", i), d_rdata, r.dack ? r.rd : 32'h0);
      chk($sformatf("r%0d conflict_cnt", i), 32'(conflict_cnt), 32'(r.cnt));
      @(posedge clk);
      #1;
    end

    // back-to-back fetches: issue every third cycle, ack two cycles after each issue
    drive(0, 1, 'hA00, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk($sformatf("b2b%0d mem_en", k), 32'(mem_en), 32'(k % 3 == 0));
      chk($sformatf("b2b%0d i_ack", k), 32'(i_ack), 32'(k % 3 == 2));
      chk($sformatf("b2b%0d d_ack", k), 32'(d_ack), 32'h0);
      if (k % 3 == 2) chk($sformatf("b2b%0d i_rdata", k), i_rdata, 32'hA00 ^ K);
      @(posedge clk);
      #1;
    end

    // flush raised in the response cycle itself suppresses the ack
    drive(0, 1, 'hB00, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rflush issue", 32'(mem_en), 32'h1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rflush wait", 32'(mem_en), 32'h0);
    @(posedge clk);
    #1;
    i_flush = 1;
    @(negedge clk);
    chk("rflush i_ack", 32'(i_ack), 32'h0);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rflush after i_ack", 32'(i_ack), 32'h0);
    chk("rflush after mem_en", 32'(mem_en), 32'h0);
    @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
